// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared AXI4-Lite definitions: bus widths, the common channel FSM state
// type and the response codes.
package axi4_lite_slave_regs_pkg;

  localparam int Addr_Width = 32;
  localparam int Data_Width = 32;

  // Four-state channel FSM shared by the AXI4-Lite master and slave.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Bank of Num_Regs data words with one byte-enabled synchronous write port,
// one combinational read port and an asynchronous active-low clear.
module axi4_lite_regfile #(
  parameter int Num_Regs   = 16,
  parameter int Data_Width = 32,
  parameter int Idx_Width  = $clog2(Num_Regs)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [Idx_Width-1:0]    wr_idx,
  input  logic [Data_Width-1:0]   wr_data,
  input  logic [Data_Width/8-1:0] wr_strb,
  input  logic [Idx_Width-1:0]    rd_idx,
  output logic [Data_Width-1:0]   rd_data
);

  localparam int Num_Lanes = Data_Width / 8;

  logic [Data_Width-1:0] regs [Num_Regs];

  // Clear every word on reset; otherwise update only the strobed byte lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Num_Regs; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < Num_Lanes; b++) begin
        if (wr_strb[b]) begin
          regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Combinational read so a read latched in the same cycle as a write
  // commit still sees the pre-write contents.
  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing a bank of 32-bit registers. Independent write and
// read FSMs; accesses outside the register window answer SLVERR.
module axi4_lite_slave_regs #(
  parameter int                        Addr_Width = axi4_lite_slave_regs_pkg::Addr_Width,
  parameter int                        Data_Width = axi4_lite_slave_regs_pkg::Data_Width,
  parameter int                        Num_Regs   = 16,
  parameter logic [Addr_Width-1:0]     Base_Addr  = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [Addr_Width-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [Data_Width-1:0]   WDATA,
  input  logic [Data_Width/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [Addr_Width-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [Data_Width-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  import axi4_lite_slave_regs_pkg::state;
  import axi4_lite_slave_regs_pkg::IDLE;
  import axi4_lite_slave_regs_pkg::ADDR;
  import axi4_lite_slave_regs_pkg::DATA;
  import axi4_lite_slave_regs_pkg::RESP;
  import axi4_lite_slave_regs_pkg::RESP_OKAY;
  import axi4_lite_slave_regs_pkg::RESP_SLVERR;

  localparam int                    Idx_Width = $clog2(Num_Regs);
  localparam logic [Addr_Width-1:0] Span      = Addr_Width'(4 * Num_Regs);

  state                  wr_state;
  state                  rd_state;
  logic [Idx_Width-1:0]  aw_idx_reg;
  logic                  aw_ok_reg;
  logic [1:0]            bresp_reg;
  logic [Data_Width-1:0] rdata_reg;
  logic [1:0]            rresp_reg;

  logic [Addr_Width-1:0] aw_offset;
  logic [Addr_Width-1:0] ar_offset;
  logic                  aw_in_range;
  logic                  ar_in_range;
  logic [Idx_Width-1:0]  aw_index;
  logic [Idx_Width-1:0]  ar_index;
  logic                  wr_en;
  logic [Data_Width-1:0] rf_rd_data;

  // Decode both address channels: byte offset from the window base, window
  // membership and word index (the low two address bits are ignored).
  always_comb begin
    aw_offset   = AWADDR - Base_Addr;
    ar_offset   = ARADDR - Base_Addr;
    aw_in_range = (AWADDR >= Base_Addr) && (aw_offset < Span);
    ar_in_range = (ARADDR >= Base_Addr) && (ar_offset < Span);
    aw_index    = aw_offset[Idx_Width+1:2];
    ar_index    = ar_offset[Idx_Width+1:2];
  end

  // Write FSM: accept the address for one cycle, wait for data, then hold
  // the response until the master takes it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state   <= IDLE;
      aw_idx_reg <= '0;
      aw_ok_reg  <= 1'b0;
      bresp_reg  <= RESP_OKAY;
    end else begin
      case (wr_state)
        IDLE: begin
          if (AWVALID) begin
            wr_state <= ADDR;
          end
        end
        ADDR: begin
          aw_idx_reg <= aw_index;
          aw_ok_reg  <= aw_in_range;
          wr_state   <= DATA;
        end
        DATA: begin
          if (WVALID) begin
            bresp_reg <= aw_ok_reg ? RESP_OKAY : RESP_SLVERR;
            wr_state  <= RESP;
          end
        end
        RESP: begin
          if (BREADY) begin
            wr_state <= IDLE;
          end
        end
        default: wr_state <= IDLE;
      endcase
    end
  end

  // Read FSM: sample the register contents while the address is accepted,
  // then present them until the master takes them.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state  <= IDLE;
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else begin
      case (rd_state)
        IDLE: begin
          if (ARVALID) begin
            rd_state <= ADDR;
          end
        end
        ADDR: begin
          rdata_reg <= ar_in_range ? rf_rd_data : '0;
          rresp_reg <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state  <= DATA;
        end
        DATA: begin
          if (RREADY) begin
            rd_state <= IDLE;
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

  // Commit only in-range writes, on the cycle the data handshake completes.
  assign wr_en = (wr_state == DATA) && WVALID && aw_ok_reg;

  axi4_lite_regfile #(
    .Num_Regs   (Num_Regs),
    .Data_Width (Data_Width),
    .Idx_Width  (Idx_Width)
  ) u_regfile (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (wr_en),
    .wr_idx  (aw_idx_reg),
    .wr_data (WDATA),
    .wr_strb (WSTRB),
    .rd_idx  (ar_index),
    .rd_data (rf_rd_data)
  );

  // Moore outputs decoded from the registered FSM states.
  assign AWREADY = (wr_state == ADDR);
  assign WREADY  = (wr_state == DATA);
  assign BVALID  = (wr_state == RESP);
  assign BRESP   = BVALID ? bresp_reg : RESP_OKAY;
  assign ARREADY = (rd_state == ADDR);
  assign RVALID  = (rd_state == DATA);
  assign RDATA   = rdata_reg;
  assign RRESP   = rresp_reg;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs (Num_Regs=16, Base_Addr=0).
// Expected read data / responses come from a bench-side register model and
// pass through a scoreboard queue.
module tb_axi4_lite_slave_regs;

  localparam int Max_Wait = 20;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_regs [16];

  axi4_lite_slave_regs #(
    .Addr_Width (32),
    .Data_Width (32),
    .Num_Regs   (16),
    .Base_Addr  (32'h0000_0000)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- register model ----------------
  function automatic bit model_in_range(input logic [31:0] addr);
    return addr < 32'h40;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    if (model_in_range(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_regs[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
  endfunction

  function automatic exp_t model_read(input logic [31:0] addr);
    exp_t e;
    if (model_in_range(addr)) begin
      e.data = model_regs[addr[5:2]];
      e.resp = 2'b00;
    end else begin
      e.data = '0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  function automatic exp_t model_wresp(input logic [31:0] addr);
    exp_t e;
    e.data = '0;
    e.resp = model_in_range(addr) ? 2'b00 : 2'b10;
    return e;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic bus_idle();
    AWADDR = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
  endtask

  // Zero-wait master write. Cycle numbers count clock periods after the one
  // in which AWVALID is first presented.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit hold_b,
                           output logic [1:0] resp, output int aw_cyc,
                           output int w_cyc, output int b_cyc);
    bit aw_pending;
    bit w_pending;
    aw_pending = 1'b0; w_pending = 1'b0;
    aw_cyc = -1; w_cyc = -1; b_cyc = -1; resp = 2'bxx;
    @(negedge ACLK);
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    BREADY = !hold_b;
    for (int cyc = 1; cyc <= Max_Wait; cyc++) begin
      @(negedge ACLK);
      if (aw_pending) begin AWVALID = 1'b0; aw_pending = 1'b0; end
      if (w_pending) begin WVALID = 1'b0; w_pending = 1'b0; end
      if (AWREADY && aw_cyc < 0) begin aw_cyc = cyc; aw_pending = 1'b1; end
      if (WREADY && w_cyc < 0) begin w_cyc = cyc; w_pending = 1'b1; end
      if (BVALID) begin b_cyc = cyc; resp = BRESP; break; end
    end
    if (b_cyc < 0) begin
      compared++; mismatched++;
      $display("FAIL write_timeout: addr=%h saw no BVALID in %0d cycles, required BVALID=1", addr, Max_Wait);
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    if (!hold_b) begin
      @(negedge ACLK);
      BREADY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int ar_cyc, output int r_cyc);
    bit ar_pending;
    ar_pending = 1'b0;
    ar_cyc = -1; r_cyc = -1; data = 'x; resp = 2'bxx;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    for (int cyc = 1; cyc <= Max_Wait; cyc++) begin
      @(negedge ACLK);
      if (ar_pending) begin ARVALID = 1'b0; ar_pending = 1'b0; end
      if (ARREADY && ar_cyc < 0) begin ar_cyc = cyc; ar_pending = 1'b1; end
      if (RVALID) begin r_cyc = cyc; data = RDATA; resp = RRESP; break; end
    end
    if (r_cyc < 0) begin
      compared++; mismatched++;
      $display("FAIL read_timeout: addr=%h saw no RVALID in %0d cycles, required RVALID=1", addr, Max_Wait);
      ARVALID = 1'b0;
    end
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rdata; logic [1:0] rresp; int ac, rc; exp_t e;
    bus_idle();
    ARESETN = 1'b0;
    model_reset();
    repeat (3) @(negedge ACLK);
    compared++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA} !== 41'd0) begin
      mismatched++;
      $display("FAIL reset_outputs_held: aw/w/b/ar/r rdy-vld=%b%b%b%b%b bresp=%b rresp=%b rdata=%h, required all 0",
               AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA);
    end
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    compared++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA} !== 41'd0) begin
      mismatched++;
      $display("FAIL reset_outputs_idle: aw/w/b/ar/r rdy-vld=%b%b%b%b%b bresp=%b rresp=%b rdata=%h, required all 0",
               AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA);
    end
    exp_q.push_back(model_read(32'h0C));
    axi_read(32'h0C, rdata, rresp, ac, rc);
    e = exp_q.pop_front();
    compared++;
    if (rdata !== e.data || rresp !== e.resp) begin
      mismatched++;
      $display("FAIL reset_reg3: rdata=%h rresp=%b, required rdata=%h rresp=%b", rdata, rresp, e.data, e.resp);
    end
    $display("test_reset: reg3 read rdata=%h rresp=%b", rdata, rresp);
  endtask

  task automatic test_write_read();
    logic [31:0] rdata; logic [1:0] resp; int ac, wc, bc, rc; exp_t e;
    model_write(32'h08, 32'hDEADBEEF, 4'hF);
    exp_q.push_back(model_wresp(32'h08));
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 1'b0, resp, ac, wc, bc);
    e = exp_q.pop_front();
    compared++;
    if (resp !== e.resp) begin
      mismatched++; $display("FAIL wr08_bresp: bresp=%b, required %b", resp, e.resp);
    end
    compared++;
    if (ac != 1 || wc != 2 || bc != 3) begin
      mismatched++;
      $display("FAIL wr08_latency: awready/wready/bvalid cycles=%0d/%0d/%0d, required 1/2/3", ac, wc, bc);
    end
    $display("test_write_read: write 0x08 bresp=%b cycles=%0d/%0d/%0d", resp, ac, wc, bc);
    exp_q.push_back(model_read(32'h08));
    axi_read(32'h08, rdata, resp, ac, rc);
    e = exp_q.pop_front();
    compared++;
    if (rdata !== e.data || resp !== e.resp) begin
      mismatched++;
      $display("FAIL rd08_data: rdata=%h rresp=%b, required rdata=%h rresp=%b", rdata, resp, e.data, e.resp);
    end
    compared++;
    if (ac != 1 || rc != 2) begin
      mismatched++;
      $display("FAIL rd08_latency: arready/rvalid cycles=%0d/%0d, required 1/2", ac, rc);
    end
    $display("test_write_read: read 0x08 rdata=%h rresp=%b cycles=%0d/%0d", rdata, resp, ac, rc);
  endtask

  task automatic test_partial();
    logic [31:0] rdata; logic [1:0] resp; int ac, wc, bc, rc; exp_t e;
    model_write(32'h10, 32'h11223344, 4'hF);
    axi_write(32'h10, 32'h11223344, 4'hF, 1'b0, resp, ac, wc, bc);
    model_write(32'h10, 32'hAABBCCDD, 4'b0101);
    axi_write(32'h10, 32'hAABBCCDD, 4'b0101, 1'b0, resp, ac, wc, bc);
    exp_q.push_back(model_read(32'h10));
    axi_read(32'h10, rdata, resp, ac, rc);
    e = exp_q.pop_front();
    compared++;
    if (rdata !== e.data || resp !== e.resp) begin
      mismatched++;
      $display("FAIL partial_model: rdata=%h rresp=%b, required rdata=%h rresp=%b", rdata, resp, e.data, e.resp);
    end
    compared++;
    if (rdata !== 32'h11BB33DD) begin
      mismatched++; $display("FAIL partial_const: rdata=%h, required 11bb33dd", rdata);
    end
    $display("test_partial: read 0x10 rdata=%h rresp=%b", rdata, resp);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rdata; logic [1:0] resp; int ac, wc, bc, rc; exp_t e;
    logic [31:0] addr;
    model_write(32'h40, 32'hFFFF_FFFF, 4'hF);
    exp_q.push_back(model_wresp(32'h40));
    axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 1'b0, resp, ac, wc, bc);
    e = exp_q.pop_front();
    compared++;
    if (resp !== e.resp) begin
      mismatched++; $display("FAIL oor_bresp: bresp=%b, required %b", resp, e.resp);
    end
    $display("test_out_of_range: write 0x40 bresp=%b", resp);
    // Out-of-range reads, the last in-range word, unaligned in-range reads
    // and a scan of every register to confirm nothing was disturbed.
    for (int i = 0; i < 20; i++) begin
      case (i)
        0: addr = 32'h40;
        1: addr = 32'hFFFF_FFFC;
        2: addr = 32'h0B;
        3: addr = 32'h3F;
        default: addr = 32'(i - 4) << 2;
      endcase
      exp_q.push_back(model_read(addr));
      axi_read(addr, rdata, resp, ac, rc);
      e = exp_q.pop_front();
      compared++;
      if (rdata !== e.data || resp !== e.resp) begin
        mismatched++;
        $display("FAIL oor_scan addr=%h: rdata=%h rresp=%b, required rdata=%h rresp=%b",
                 addr, rdata, resp, e.data, e.resp);
      end
      $display("test_out_of_range: read %h rdata=%h rresp=%b", addr, rdata, resp);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; int ac, wc, bc;
    model_write(32'h14, 32'hCAFEF00D, 4'hF);
    axi_write(32'h14, 32'hCAFEF00D, 4'hF, 1'b1, resp, ac, wc, bc);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      compared++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
        mismatched++;
        $display("FAIL bp_hold cycle %0d: bvalid=%b bresp=%b, required bvalid=1 bresp=00", i, BVALID, BRESP);
      end
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    compared++;
    if (BVALID !== 1'b0) begin
      mismatched++; $display("FAIL bp_release: bvalid=%b, required 0", BVALID);
    end
    $display("test_backpressure: write 0x14 held 5 cycles, bresp=%b", resp);
  endtask

  task automatic test_w_before_aw();
    logic [31:0] rdata; logic [1:0] resp; int ac, rc; exp_t e;
    @(negedge ACLK);
    WDATA = 32'h0BADCAFE; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      compared++;
      if (WREADY !== 1'b0) begin
        mismatched++; $display("FAIL wfirst_idle cycle %0d: wready=%b, required 0", i, WREADY);
      end
    end
    AWADDR = 32'h18; AWVALID = 1'b1;
    @(negedge ACLK);
    compared++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
      mismatched++;
      $display("FAIL wfirst_addr: awready=%b wready=%b, required awready=1 wready=0", AWREADY, WREADY);
    end
    @(negedge ACLK);
    AWVALID = 1'b0;
    compared++;
    if (WREADY !== 1'b1) begin
      mismatched++; $display("FAIL wfirst_data: wready=%b, required 1", WREADY);
    end
    @(negedge ACLK);
    WVALID = 1'b0;
    compared++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      mismatched++; $display("FAIL wfirst_resp: bvalid=%b bresp=%b, required 1/00", BVALID, BRESP);
    end
    @(negedge ACLK);
    BREADY = 1'b0;
    model_write(32'h18, 32'h0BADCAFE, 4'hF);
    exp_q.push_back(model_read(32'h18));
    axi_read(32'h18, rdata, resp, ac, rc);
    e = exp_q.pop_front();
    compared++;
    if (rdata !== e.data || resp !== e.resp) begin
      mismatched++;
      $display("FAIL wfirst_read: rdata=%h rresp=%b, required rdata=%h rresp=%b", rdata, resp, e.data, e.resp);
    end
    $display("test_w_before_aw: read 0x18 rdata=%h rresp=%b", rdata, resp);
  endtask

  task automatic test_concurrency();
    logic [31:0] rdata; logic [1:0] rresp, bresp; int ac, wc, bc, arc, rc; exp_t e;
    model_write(32'h04, 32'h5, 4'hF);
    axi_write(32'h04, 32'h5, 4'hF, 1'b0, bresp, ac, wc, bc);
    // Read address is presented one cycle after the write address, so the
    // read is latched in the same cycle the write commits.
    exp_q.push_back(model_read(32'h04));
    model_write(32'h04, 32'h9, 4'hF);
    fork
      axi_write(32'h04, 32'h9, 4'hF, 1'b0, bresp, ac, wc, bc);
      begin
        @(negedge ACLK);
        axi_read(32'h04, rdata, rresp, arc, rc);
      end
    join
    e = exp_q.pop_front();
    compared++;
    if (rdata !== e.data || rresp !== e.resp) begin
      mismatched++;
      $display("FAIL collide_old: rdata=%h rresp=%b, required rdata=%h rresp=%b", rdata, rresp, e.data, e.resp);
    end
    $display("test_concurrency: colliding read rdata=%h, write bresp=%b", rdata, bresp);
    exp_q.push_back(model_read(32'h04));
    axi_read(32'h04, rdata, rresp, arc, rc);
    e = exp_q.pop_front();
    compared++;
    if (rdata !== e.data || rresp !== e.resp) begin
      mismatched++;
      $display("FAIL collide_new: rdata=%h rresp=%b, required rdata=%h rresp=%b", rdata, rresp, e.data, e.resp);
    end
    $display("test_concurrency: later read rdata=%h", rdata);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rdata; logic [1:0] resp; int ac, rc; exp_t e;
    @(negedge ACLK);
    AWADDR = 32'h04; AWVALID = 1'b1; WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    compared++;
    if (WREADY !== 1'b1) begin
      mismatched++; $display("FAIL midrst_in_data: wready=%b, required 1", WREADY);
    end
    ARESETN = 1'b0;
    #1;
    compared++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA} !== 41'd0) begin
      mismatched++;
      $display("FAIL midrst_outputs: aw/w/b/ar/r rdy-vld=%b%b%b%b%b bresp=%b rresp=%b rdata=%h, required all 0",
               AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA);
    end
    model_reset();
    repeat (2) @(negedge ACLK);
    bus_idle();
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    compared++;
    if ({WREADY, BVALID} !== 2'b00) begin
      mismatched++; $display("FAIL midrst_after: wready=%b bvalid=%b, required 0/0", WREADY, BVALID);
    end
    exp_q.push_back(model_read(32'h04));
    axi_read(32'h04, rdata, resp, ac, rc);
    e = exp_q.pop_front();
    compared++;
    if (rdata !== e.data || resp !== e.resp) begin
      mismatched++;
      $display("FAIL midrst_reg: rdata=%h rresp=%b, required rdata=%h rresp=%b", rdata, resp, e.data, e.resp);
    end
    $display("test_reset_mid_write: read 0x04 rdata=%h rresp=%b", rdata, resp);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr, data, rdata; logic [3:0] strb; logic [1:0] resp;
    int ac, wc, bc, rc; exp_t e;
    for (int i = 0; i < 10; i++) begin
      addr = 32'($urandom_range(0, 15)) << 2;
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      model_write(addr, data, strb);
      exp_q.push_back(model_wresp(addr));
      axi_write(addr, data, strb, 1'b0, resp, ac, wc, bc);
      e = exp_q.pop_front();
      compared++;
      if (resp !== e.resp) begin
        mismatched++; $display("FAIL b2b_bresp addr=%h: bresp=%b, required %b", addr, resp, e.resp);
      end
      $display("test_back_to_back: write %h data=%h strb=%b bresp=%b", addr, data, strb, resp);
    end
    for (int i = 0; i < 16; i++) begin
      addr = 32'(i) << 2;
      exp_q.push_back(model_read(addr));
      axi_read(addr, rdata, resp, ac, rc);
      e = exp_q.pop_front();
      compared++;
      if (rdata !== e.data || resp !== e.resp) begin
        mismatched++;
        $display("FAIL b2b_read addr=%h: rdata=%h rresp=%b, required rdata=%h rresp=%b",
                 addr, rdata, resp, e.data, e.resp);
      end
      $display("test_back_to_back: read %h rdata=%h rresp=%b", addr, rdata, resp);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_out_of_range();
    test_backpressure();
    test_w_before_aw();
    test_concurrency();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite slave endpoint that consumes transactions issued by the team's AXI4-Lite master and maps them onto a bank of memory-mapped 32-bit registers. It sits directly downstream of the master on the same bus. It runs independent write and read state machines built on the shared four-state `state` type (IDLE, ADDR, DATA, RESP). Out-of-range accesses return SLVERR.

## Interface
Parameters:
- `Addr_Width`, 32, address width (matches package value)
- `Data_Width`, 32, data width (matches package value; only 32 supported)
- `Num_Regs`, 16, number of registers; power of two, 2..256
- `Base_Addr`, 32'h0000_0000, byte address of register 0; aligned to 4*Num_Regs

Ports:
- `ACLK` in 1: clock. One clock; all logic on the rising edge.
- `ARESETN` in 1: reset, asynchronous, active-low.
- `AWADDR` in Addr_Width; `AWVALID` in 1; `AWREADY` out 1: write address channel
- `WDATA` in Data_Width; `WSTRB` in Data_Width/8; `WVALID` in 1; `WREADY` out 1: write data channel
- `BRESP` out 2; `BVALID` out 1; `BREADY` in 1: write response channel
- `ARADDR` in Addr_Width; `ARVALID` in 1; `ARREADY` out 1: read address channel
- `RDATA` out Data_Width; `RRESP` out 2; `RVALID` out 1; `RREADY` in 1: read data channel

## Operation
Write FSM (Moore; outputs decoded from the registered state):
- IDLE: all write outputs 0. If AWVALID, go to ADDR.
- ADDR: AWREADY=1 for exactly one cycle. Latch AWADDR and the decode result. Go to DATA.
- DATA: WREADY=1. On WVALID, write the addressed register if in range, byte lane i only when WSTRB[i]=1. Capture BRESP. Go to RESP. Otherwise hold.
- RESP: BVALID=1 with the captured BRESP. Hold until BREADY, then go to IDLE.

Read FSM:
- IDLE: if ARVALID, go to ADDR.
- ADDR: ARREADY=1 for one cycle. Latch ARADDR. Register RDATA/RRESP from the current register contents. Go to DATA.
- DATA: RVALID=1. RDATA/RRESP held stable until RREADY, then go to IDLE.
- RESP is unused by the read FSM. Any illegal state goes to IDLE.

Address decode:
- Offset = addr − Base_Addr. In range iff Base_Addr ≤ addr < Base_Addr + 4*Num_Regs.
- Index = offset[log2(Num_Regs)+1:2]. addr[1:0] are ignored, so unaligned addresses are treated as aligned.
- In range: response OKAY (2'b00).
- Out of range: SLVERR (2'b10). Writes are dropped and reads return RDATA=0.

Other rules:
- Write and read FSMs are fully independent and may run concurrently.
- W arriving before AW is legal. WDATA waits (WREADY=0) until the write FSM reaches DATA.

## Timing
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP = 2'b00; RDATA = 0. All registers 0. Both FSMs in IDLE.
- Write, zero-wait master: AWVALID seen at cycle 0 → AWREADY in cycle 1 → WREADY in cycle 2 (register written at the end of cycle 2) → BVALID in cycle 3. The new value is visible to reads latched from cycle 3 on.
- Read: ARVALID at cycle 0 → ARREADY in cycle 1 → RVALID in cycle 2.
- Back-to-back: after the BREADY/RREADY handshake the FSM returns to IDLE for one cycle. Minimum spacing is 4 cycles per write and 3 per read.
- Same-register collision: if a read is latched (ADDR) in the same cycle a write commits (DATA with WVALID), the read returns the old value.
- BVALID/RVALID stay high with stable payload while BREADY/RREADY=0, indefinitely.
- ARESETN asserted mid-transaction: abort immediately, with outputs at their reset values. A write that has not yet reached its DATA commit edge leaves registers unchanged.

## Structure
- The shared package already provides `Addr_Width`, `Data_Width` and the `state` enum. Add to it: `RESP_OKAY`=2'b00, `RESP_SLVERR`=2'b10.
- Sub-module `axi4_lite_regfile`: Num_Regs×32 storage, one write port with byte enables, one combinational read port, async active-low clear.
- Top level holds the two FSMs, the address latches and the decode.

## Test plan
- Reset checks: all outputs and register 3 read as 0 after reset; every state in IDLE.
- Write 0xDEADBEEF to 0x08 with WSTRB=4'hF, then read 0x08 → RDATA=0xDEADBEEF, RRESP=00, BRESP=00. Cycle counts must match the write and read latencies above.
- Partial write: write 0x11223344 (strobe F), then write 0xAABBCCDD with WSTRB=4'b0101 to the same register. A read must return 0x11BB33DD.
- Out of range with Num_Regs=16: write to 0x40 gives BRESP=10 and no register changes. Read from 0x40 gives RRESP=10, RDATA=0.
- Backpressure and ordering: hold BREADY=0 for 5 cycles and check BVALID/BRESP stay stable. Drive WVALID 3 cycles before AWVALID and check WREADY stays 0 until the DATA state.
- Concurrency and reset: a read and a write to 0x04 latch in the same cycle, with reg=0x5 and the write data 0x9. The read must return 0x5 and a later read 0x9. Then assert ARESETN low during a write's DATA state before WVALID; the register stays unchanged and all outputs go to 0.
